// File: rtl/mapa_pkg.sv
// Shared types for the minterm sweep engine: FSM states, default sizing,
// and a popcount helper used by scoreboards that count sparse beats.
package mapa_pkg;

    localparam int DEF_N_VARS   = 4;
    localparam int DEF_CHANNELS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mapa_mask_bank.sv
// Minterm mask storage with guarded writes, a registered lookup port and a
// combinational column read used by the sweep engine.
module mapa_mask_bank
    import mapa_pkg::*;
#(
    parameter int N_VARS   = DEF_N_VARS,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int TABLE   = 2 ** N_VARS,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                busy,
    input  logic [CH_W-1:0]     ch,
    input  logic [TABLE-1:0]    wdata,
    output logic                err,
    input  logic [N_VARS-1:0]   lk_addr,
    output logic [CHANNELS-1:0] lk_bits,
    input  logic [N_VARS-1:0]   sw_addr,
    output logic [CHANNELS-1:0] sw_bits
);

    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

    logic [TABLE-1:0]    masks [CHANNELS];
    logic [CHANNELS-1:0] lk_next;
    logic                ch_ok;

    assign ch_ok = ({1'b0, ch} < CH_LIM);

    // Lookup reads the stored masks, so a write lands in lk_bits one edge later.
    always_comb begin
        lk_next = '0;
        sw_bits = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            lk_next[c] = masks[c][lk_addr];
            sw_bits[c] = masks[c][sw_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                masks[c] <= '0;
            end
            err     <= 1'b0;
            lk_bits <= '0;
        end else begin
            if (we && !busy && ch_ok) begin
                masks[ch] <= wdata;
            end
            err     <= we && (busy || !ch_ok);
            lk_bits <= lk_next;
        end
    end

endmodule

// File: rtl/mapa_minterm_sweep.sv
// Programmable truth-table engine: registered lookup plus a dense/sparse
// sweep that streams truth-table rows over a valid/ready port.
module mapa_minterm_sweep
    import mapa_pkg::*;
#(
    parameter int N_VARS   = DEF_N_VARS,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int TABLE   = 2 ** N_VARS,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [TABLE-1:0]    cfg_mask,
    output logic                cfg_err,
    input  logic [N_VARS-1:0]   in_vars,
    output logic [CHANNELS-1:0] eval_bits,
    input  logic                start,
    input  logic                sparse,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_VARS-1:0]   out_index,
    output logic [CHANNELS-1:0] out_bits,
    output logic                out_last,
    output logic                done
);

    localparam logic [N_VARS:0] LAST_IDX = (N_VARS + 1)'(TABLE - 1);

    state_t              state, state_nx;
    logic [N_VARS:0]     idx, idx_nx;
    logic                sparse_q, sparse_nx;
    logic [CHANNELS-1:0] row_bits;
    logic                row_last;
    logic                advance;

    mapa_mask_bank #(
        .N_VARS   (N_VARS),
        .CHANNELS (CHANNELS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (cfg_we),
        .busy    (busy),
        .ch      (cfg_ch),
        .wdata   (cfg_mask),
        .err     (cfg_err),
        .lk_addr (in_vars),
        .lk_bits (eval_bits),
        .sw_addr (idx[N_VARS-1:0]),
        .sw_bits (row_bits)
    );

    assign row_last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            sparse_q <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            sparse_q <= sparse_nx;
        end
    end

    // Stream handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and while
    // out_valid is high without out_ready the index, bits and last flag hold.
    // Sparse mode skips all-zero rows one per cycle with out_valid low.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        sparse_nx = sparse_q;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_index = '0;
        out_bits  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SWEEP;
                    idx_nx    = '0;
                    sparse_nx = sparse;
                end
            end
            SWEEP: begin
                busy      = 1'b1;
                out_index = idx[N_VARS-1:0];
                out_bits  = row_bits;
                out_last  = row_last;
                out_valid = !sparse_q || (|row_bits);
                advance   = !out_valid || out_ready;
                if (advance) begin
                    if (row_last) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mapa_minterm_sweep.sv
// Self-checking bench for mapa_minterm_sweep: directed and randomized sweeps
// scored against a truth-table model built from the stored masks.
module tb_mapa_minterm_sweep;
    import mapa_pkg::*;

    localparam int N     = 4;
    localparam int CH    = 5;
    localparam int TABLE = 16;
    localparam int CH_W  = 3;
    localparam int W     = N + CH + 1;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [TABLE-1:0] cfg_mask;
    logic             cfg_err;
    logic [N-1:0]     in_vars;
    logic [CH-1:0]    eval_bits;
    logic             start;
    logic             sparse;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_index;
    logic [CH-1:0]    out_bits;
    logic             out_last;
    logic             done;

    mapa_minterm_sweep dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mask  (cfg_mask),
        .cfg_err   (cfg_err),
        .in_vars   (in_vars),
        .eval_bits (eval_bits),
        .start     (start),
        .sparse    (sparse),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .done      (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    logic [TABLE-1:0] model_mask [CH];
    logic [W-1:0]     exp_q[$];
    int               checks;
    int               failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] model_row(input int r);
        logic [CH-1:0] b;
        for (int c = 0; c < CH; c++) b[c] = model_mask[c][r];
        return b;
    endfunction

    task automatic build_exp(input bit sp);
        logic [CH-1:0] b;
        exp_q.delete();
        for (int r = 0; r < TABLE; r++) begin
            b = model_row(r);
            if (!sp || b != '0) exp_q.push_back({N'(r), b, (r == TABLE - 1)});
        end
    endtask

    // ---------------- drivers (enter and leave on a falling edge) ----------------
    task automatic cfg_write(input int ch, input logic [TABLE-1:0] m);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_mask = m;
        @(negedge clk);
        cfg_we = 1'b0;
        if (ch < CH) model_mask[ch] = m;
        check("cfg_err", cfg_err, (ch >= CH));
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1'b0);
    endtask

    task automatic lookup(input int v);
        in_vars = N'(v);
        @(negedge clk);
        check("eval_bits", eval_bits, model_row(v));
    endtask

    // mode 0: ready held high; 1: stall stall_len cycles on row stall_idx; 2: random ready
    task automatic run_sweep(input bit sp, input int mode, input int stall_idx, input int stall_len,
                             input int rej_at, input bit wr_with_start, input logic [TABLE-1:0] wr_mask);
        int r, stalled, nbeats;
        bit fin, rdy, ev;
        logic [TABLE-1:0] any;
        if (wr_with_start) begin
            cfg_we = 1'b1; cfg_ch = 3'd3; cfg_mask = wr_mask;
            model_mask[3] = wr_mask;
        end
        build_exp(sp);
        any = '0;
        for (int c = 0; c < CH; c++) any |= model_mask[c];
        start = 1'b1; sparse = sp;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0; sparse = 1'($urandom_range(0, 1));
        r = 0; stalled = 0; nbeats = 0; fin = 1'b0;
        for (int c = 1; c < 200 && !fin; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(r == stall_idx && stalled < stall_len);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 1 && !rdy) stalled++;
            out_ready = rdy;
            start     = (r == TABLE) || (c == 3);
            if (rej_at == c) begin
                cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mask = 16'hFFFF;
            end else begin
                cfg_we = 1'b0;
            end
            if (rej_at > 0 && c == rej_at + 1) check("cfg_err_busy", cfg_err, 1'b1);
            if (r < TABLE) begin
                ev = (exp_q.size() > 0) && (exp_q[0][W-1 -: N] == N'(r));
                check("busy", busy, 1'b1);
                check("out_valid", out_valid, ev);
                check("done_early", done, 1'b0);
                if (ev) begin
                    check("beat", {out_index, out_bits, out_last}, exp_q[0]);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        nbeats++;
                        r++;
                    end
                end else begin
                    r++;
                end
            end else begin
                check("done", done, 1'b1);
                check("valid_in_done", out_valid, 1'b0);
                check("queue_drained", exp_q.size(), 0);
                fin = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        if (!fin) check("sweep_timeout", 0, 1);
        check("beat_count", nbeats, sp ? popcount(32'(any)) : TABLE);
        check("done_single", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mask = '0; in_vars = '0;
        start = 1'b0; sparse = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < CH; c++) model_mask[c] = '0;
        repeat (3) @(negedge clk);
        check("rst_eval", eval_bits, 0);
        check("rst_valid", out_valid, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // lookup latency around a write to ch4
        cfg_we = 1'b1; cfg_ch = 3'd4; cfg_mask = 16'hAA87; in_vars = 4'd7;
        @(negedge clk);
        cfg_we = 1'b0;
        check("eval_before_write", eval_bits, 0);
        model_mask[4] = 16'hAA87;
        @(negedge clk);
        check("eval_after_write", eval_bits, 5'b10000);
        in_vars = 4'd8;
        @(negedge clk);
        check("eval_row8", eval_bits, 0);

        cfg_write(0, 16'h88CA);
        for (int i = 0; i < 16; i++) lookup($urandom_range(0, TABLE - 1));

        run_sweep(1'b0, 0, 0, 0, 0, 1'b0, '0);          // dense
        cfg_write(4, 16'h0000);
        run_sweep(1'b1, 0, 0, 0, 0, 1'b0, '0);          // sparse, ch0 only
        cfg_write(4, 16'hAA87);
        run_sweep(1'b0, 1, 3, 5, 6, 1'b0, '0);          // backpressure + busy write
        for (int v = 0; v < TABLE; v++) lookup(v);

        cfg_write(5, 16'hFFFF);
        cfg_write(7, 16'h1234);
        for (int v = 0; v < TABLE; v++) lookup(v);

        // reset in the middle of a dense sweep
        start = 1'b1; sparse = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("idx_before_reset", out_index, 9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        for (int c = 0; c < CH; c++) model_mask[c] = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_reset", {done, out_valid}, 0);
        end
        for (int v = 0; v < TABLE; v++) lookup(v);

        run_sweep(1'b1, 0, 0, 0, 0, 1'b0, '0);          // all-zero sparse

        // randomized masks, modes and backpressure
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < CH; c++) cfg_write(c, TABLE'($urandom & $urandom & $urandom));
            run_sweep(1'($urandom_range(0, 1)), 2, 0, 0, (t == 2) ? 9 : 0,
                      1'($urandom_range(0, 1)), TABLE'($urandom));
            for (int i = 0; i < 6; i++) lookup($urandom_range(0, TABLE - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
